// File: rtl/tx_scheduler_pkg.sv
// Shared definitions for the UART transmit scheduler: state encoding,
// start-timeout length, line-configuration field widths and the arbiter reset grant.
package tx_scheduler_pkg;

   typedef enum logic [2:0] {
      ST_DISABLED,
      ST_IDLE,
      ST_START,
      ST_WAIT_DONE,
      ST_GAP
   } sched_state_e;

   localparam int unsigned START_TIMEOUT = 32;
   localparam int unsigned TMO_W         = $clog2(START_TIMEOUT);

   localparam int unsigned CONF_DATA_W   = 2;
   localparam int unsigned CONF_STOP_W   = 2;
   localparam int unsigned CONF_PARITY_W = 1;
   localparam int unsigned CONF_W        = CONF_DATA_W + CONF_STOP_W + CONF_PARITY_W;

   // Requester 0 wins the first tie after reset.
   localparam logic GRANT_RST = 1'b1;

endpackage

// File: rtl/tx_scheduler_rr_arbiter2.sv
// Two-input round-robin arbiter: on a tie, grants the requester that did
// not win last time; otherwise grants whichever requester is valid.
module rr_arbiter2 (
   input  logic [1:0] valid_i,
   input  logic       last_grant_i,
   output logic       any_o,
   output logic       grant_o
);

   always_comb begin
      any_o   = |valid_i;
      grant_o = last_grant_i;
      if (&valid_i) begin
         grant_o = ~last_grant_i;
      end else if (valid_i[1]) begin
         grant_o = 1'b1;
      end else if (valid_i[0]) begin
         grant_o = 1'b0;
      end
   end

endmodule

// File: rtl/tx_scheduler.sv
// Schedules characters from two requesters onto one UART Tx module, with
// round-robin arbitration, start timeout, inter-character gap and a character counter.
module tx_scheduler
   import tx_scheduler_pkg::*;
#(
   parameter int unsigned MAX_UART_DATA_W  = 8,
   parameter int unsigned TOTAL_CONF_WIDTH = CONF_W,
   parameter int unsigned GAP_W            = 8
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        baud_en_i,
   input  logic                        enable_i,
   input  logic [GAP_W-1:0]            gap_i,
   input  logic [TOTAL_CONF_WIDTH-1:0] tx_conf_i,
   input  logic                        req0_valid_i,
   input  logic [MAX_UART_DATA_W-1:0]  req0_data_i,
   output logic                        req0_ready_o,
   input  logic                        req1_valid_i,
   input  logic [MAX_UART_DATA_W-1:0]  req1_data_i,
   output logic                        req1_ready_o,
   input  logic                        tx_busy_i,
   input  logic                        tx_done_i,
   output logic                        tx_en_o,
   output logic                        tx_start_o,
   output logic [MAX_UART_DATA_W-1:0]  tx_data_o,
   output logic [TOTAL_CONF_WIDTH-1:0] tx_conf_o,
   output logic                        grant_o,
   output logic                        sched_busy_o,
   output logic [15:0]                 char_count_o,
   output logic                        err_o,
   input  logic                        err_clr_i
);

   sched_state_e                  state_q, state_d;
   logic [MAX_UART_DATA_W-1:0]    data_q, data_d;
   logic [TOTAL_CONF_WIDTH-1:0]   conf_q, conf_d;
   logic                          grant_q, grant_d;
   logic [15:0]                   char_count_q, char_count_d;
   logic                          err_q, err_d;
   logic [TMO_W-1:0]              tmo_q, tmo_d;
   logic [GAP_W-1:0]              gap_q, gap_d;

   logic                          arb_any;
   logic                          arb_grant;
   logic                          accept;
   logic                          err_set;

   rr_arbiter2 u_arb (
      .valid_i      ({req1_valid_i, req0_valid_i}),
      .last_grant_i (grant_q),
      .any_o        (arb_any),
      .grant_o      (arb_grant)
   );

   always_comb begin
      state_d      = state_q;
      data_d       = data_q;
      conf_d       = conf_q;
      grant_d      = grant_q;
      char_count_d = char_count_q;
      tmo_d        = tmo_q;
      gap_d        = gap_q;
      accept       = 1'b0;
      err_set      = 1'b0;

      unique case (state_q)
         ST_DISABLED: begin
            if (enable_i) state_d = ST_IDLE;
         end
         ST_IDLE: begin
            // A disabled scheduler ignores pending requests.
            if (!enable_i) begin
               state_d = ST_DISABLED;
            end else if (arb_any) begin
               accept  = 1'b1;
               data_d  = arb_grant ? req1_data_i : req0_data_i;
               conf_d  = tx_conf_i;
               grant_d = arb_grant;
               tmo_d   = '0;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (tx_busy_i) begin
               state_d = ST_WAIT_DONE;
            end else if (baud_en_i) begin
               if (tmo_q == TMO_W'(START_TIMEOUT - 1)) begin
                  err_set = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  tmo_d = tmo_q + 1'b1;
               end
            end
         end
         ST_WAIT_DONE: begin
            if (tx_done_i) begin
               char_count_d = char_count_q + 16'd1;
               if (gap_i != '0) begin
                  gap_d   = gap_i;
                  state_d = ST_GAP;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_GAP: begin
            // gap_q holds the ticks still to wait, including the current one.
            if (baud_en_i) begin
               if (gap_q == GAP_W'(1)) begin
                  state_d = ST_IDLE;
               end else begin
                  gap_d = gap_q - 1'b1;
               end
            end
         end
         default: state_d = ST_DISABLED;
      endcase

      err_d = err_q;
      if (err_clr_i) err_d = 1'b0;
      if (err_set)   err_d = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_DISABLED;
         data_q       <= '0;
         conf_q       <= '0;
         grant_q      <= GRANT_RST;
         char_count_q <= '0;
         err_q        <= 1'b0;
         tmo_q        <= '0;
         gap_q        <= '0;
      end else begin
         state_q      <= state_d;
         data_q       <= data_d;
         conf_q       <= conf_d;
         grant_q      <= grant_d;
         char_count_q <= char_count_d;
         err_q        <= err_d;
         tmo_q        <= tmo_d;
         gap_q        <= gap_d;
      end
   end

   assign req0_ready_o = accept & ~arb_grant & ~rst_i;
   assign req1_ready_o = accept &  arb_grant & ~rst_i;
   assign tx_start_o   = (state_q == ST_START);
   assign sched_busy_o = (state_q == ST_START) || (state_q == ST_WAIT_DONE) || (state_q == ST_GAP);
   assign tx_en_o      = enable_i || ((state_q != ST_DISABLED) && (state_q != ST_IDLE));
   assign tx_data_o    = data_q;
   assign tx_conf_o    = conf_q;
   assign grant_o      = grant_q;
   assign char_count_o = char_count_q;
   assign err_o        = err_q;

endmodule

// File: tb/tb_tx_scheduler.sv
// Directed self-checking bench for tx_scheduler: reset values, single request,
// contention, gap timing, start timeout, enable drop, counter wrap and mid-character reset.
module tb_tx_scheduler;

   localparam int unsigned DW = 8;
   localparam int unsigned CW = 5;
   localparam int unsigned GW = 8;

   logic          clk = 1'b0;
   logic          rst, baud_en, enable, err_clr;
   logic [GW-1:0] gap;
   logic [CW-1:0] conf;
   logic          req0_valid, req1_valid;
   logic [DW-1:0] d0, d1;
   logic          tx_busy, tx_done;

   logic          req0_ready, req1_ready, tx_en, tx_start, grant, sched_busy, err;
   logic [DW-1:0] tx_data;
   logic [CW-1:0] tx_conf;
   logic [15:0]   char_count;

   int unsigned   n_checks = 0;
   int unsigned   n_pass   = 0;
   int unsigned   ticks;
   logic          found;
   logic          exp_g;

   always #5 clk = ~clk;

   tx_scheduler #(
      .MAX_UART_DATA_W  (DW),
      .TOTAL_CONF_WIDTH (CW),
      .GAP_W            (GW)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .baud_en_i    (baud_en),
      .enable_i     (enable),
      .gap_i        (gap),
      .tx_conf_i    (conf),
      .req0_valid_i (req0_valid),
      .req0_data_i  (d0),
      .req0_ready_o (req0_ready),
      .req1_valid_i (req1_valid),
      .req1_data_i  (d1),
      .req1_ready_o (req1_ready),
      .tx_busy_i    (tx_busy),
      .tx_done_i    (tx_done),
      .tx_en_o      (tx_en),
      .tx_start_o   (tx_start),
      .tx_data_o    (tx_data),
      .tx_conf_o    (tx_conf),
      .grant_o      (grant),
      .sched_busy_o (sched_busy),
      .char_count_o (char_count),
      .err_o        (err),
      .err_clr_i    (err_clr)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // From Start: Tx reports busy, then a done pulse one cycle later.
   task automatic finish_char();
      tx_busy = 1'b1;
      step();
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      tx_busy = 1'b0;
      #1;
   endtask

   task automatic chk_reset(input string pfx, input logic exp_en);
      chk({pfx, "_tx_start"},   32'(tx_start),   32'd0);
      chk({pfx, "_ready0"},     32'(req0_ready), 32'd0);
      chk({pfx, "_ready1"},     32'(req1_ready), 32'd0);
      chk({pfx, "_err"},        32'(err),        32'd0);
      chk({pfx, "_sched_busy"}, 32'(sched_busy), 32'd0);
      chk({pfx, "_grant"},      32'(grant),      32'd1);
      chk({pfx, "_char_count"}, 32'(char_count), 32'd0);
      chk({pfx, "_tx_data"},    32'(tx_data),    32'd0);
      chk({pfx, "_tx_conf"},    32'(tx_conf),    32'd0);
      chk({pfx, "_tx_en"},      32'(tx_en),      32'(exp_en));
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; baud_en = 1'b0; enable = 1'b0; err_clr = 1'b0;
      gap = '0; conf = '0; req0_valid = 1'b0; req1_valid = 1'b0;
      d0 = '0; d1 = '0; tx_busy = 1'b0; tx_done = 1'b0;
      step();
      step();
      rst = 1'b0;
      #1;
      chk_reset("rst", 1'b0);

      // Single request from requester 0
      enable = 1'b1;
      step();
      chk("t1_tx_en_idle", 32'(tx_en), 32'd1);
      d0 = 8'hA5; conf = 5'b11001; req0_valid = 1'b1;
      #1;
      chk("t1_ready0", 32'(req0_ready), 32'd1);
      chk("t1_ready1", 32'(req1_ready), 32'd0);
      step();
      req0_valid = 1'b0;
      #1;
      chk("t1_ready0_pulse", 32'(req0_ready), 32'd0);
      chk("t1_tx_start",     32'(tx_start),   32'd1);
      chk("t1_tx_data",      32'(tx_data),    32'hA5);
      chk("t1_tx_conf",      32'(tx_conf),    32'h19);
      chk("t1_grant",        32'(grant),      32'd0);
      chk("t1_sched_busy",   32'(sched_busy), 32'd1);
      step();
      step();
      chk("t1_start_held", 32'(tx_start), 32'd1);
      tx_busy = 1'b1;
      step();
      chk("t1_start_drop", 32'(tx_start),   32'd0);
      chk("t1_busy_wait",  32'(sched_busy), 32'd1);
      tx_done = 1'b1;
      step();
      tx_done = 1'b0; tx_busy = 1'b0;
      #1;
      chk("t1_count",     32'(char_count), 32'd1);
      chk("t1_idle_busy", 32'(sched_busy), 32'd0);

      // Contention: round-robin from a fresh reset
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      d0 = 8'h11; d1 = 8'h22; req0_valid = 1'b1; req1_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_g = (i % 2) == 1;
         #1;
         chk("t2_ready0", 32'(req0_ready), 32'(!exp_g));
         chk("t2_ready1", 32'(req1_ready), 32'(exp_g));
         step();
         chk("t2_data",        32'(tx_data), exp_g ? 32'h22 : 32'h11);
         chk("t2_grant",       32'(grant),   32'(exp_g));
         chk("t2_no_ready_st", 32'(req0_ready | req1_ready), 32'd0);
         finish_char();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      chk("t2_count", 32'(char_count), 32'd4);

      // Gap of 3 baud ticks; gap_i changes after Gap entry must not matter
      gap = 8'd3; d0 = 8'h5A; req0_valid = 1'b1;
      step();
      finish_char();
      gap = 8'd0;
      chk("t3_in_gap", 32'(sched_busy), 32'd1);
      ticks = 0;
      found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
         #1;
         if (req0_ready) begin
            found = 1'b1;
         end else begin
            baud_en = (c % 2) == 1;
            step();
            if (baud_en) ticks++;
            baud_en = 1'b0;
         end
      end
      chk("t3_ready_seen", 32'(found),   32'd1);
      chk("t3_gap_ticks",  ticks,        32'd3);
      chk("t3_data_held",  32'(tx_data), 32'h5A);
      step();
      req0_valid = 1'b0;
      finish_char();
      chk("t3_count", 32'(char_count), 32'd6);

      // Start timeout: busy never arrives
      d1 = 8'h3C; req1_valid = 1'b1;
      #1;
      step();
      req1_valid = 1'b0;
      chk("t4_grant", 32'(grant), 32'd1);
      ticks = 0;
      for (int c = 0; c < 100 && !err; c++) begin
         if (ticks == 31) chk("t4_start_before", 32'(tx_start), 32'd1);
         baud_en = 1'b1;
         step();
         baud_en = 1'b0;
         ticks++;
      end
      chk("t4_err",        32'(err),        32'd1);
      chk("t4_ticks",      ticks,           32'd32);
      chk("t4_start_drop", 32'(tx_start),   32'd0);
      chk("t4_idle",       32'(sched_busy), 32'd0);
      chk("t4_count",      32'(char_count), 32'd6);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      chk("t4_err_clr", 32'(err), 32'd0);

      // Enable dropped during WaitDone
      d0 = 8'h77; req0_valid = 1'b1;
      #1;
      step();
      req0_valid = 1'b0;
      tx_busy = 1'b1;
      step();
      enable = 1'b0; req1_valid = 1'b1;
      #1;
      chk("t5_tx_en_wait", 32'(tx_en),      32'd1);
      chk("t5_ready1",     32'(req1_ready), 32'd0);
      step();
      chk("t5_tx_en_wait2", 32'(tx_en),      32'd1);
      chk("t5_busy_wait",   32'(sched_busy), 32'd1);
      tx_done = 1'b1;
      step();
      tx_done = 1'b0; tx_busy = 1'b0;
      #1;
      chk("t5_count",       32'(char_count), 32'd7);
      chk("t5_tx_en_idle",  32'(tx_en),      32'd0);
      chk("t5_ready1_idle", 32'(req1_ready), 32'd0);
      step();
      chk("t5_ready1_dis", 32'(req1_ready), 32'd0);
      chk("t5_tx_en_dis",  32'(tx_en),      32'd0);
      chk("t5_busy_dis",   32'(sched_busy), 32'd0);
      step();
      chk("t5_grant_kept", 32'(grant), 32'd0);
      req1_valid = 1'b0;

      // Counter wrap
      enable = 1'b1;
      step();
      force dut.char_count_q = 16'hFFFF;
      step();
      release dut.char_count_q;
      #1;
      chk("t6_count_preset", 32'(char_count), 32'hFFFF);
      d0 = 8'h01; req0_valid = 1'b1;
      #1;
      step();
      req0_valid = 1'b0;
      finish_char();
      chk("t6_count_wrap", 32'(char_count), 32'd0);

      // Reset while in Start
      d1 = 8'h99; req1_valid = 1'b1;
      #1;
      step();
      req1_valid = 1'b0;
      #1;
      chk("t7_in_start", 32'(tx_start), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      chk_reset("t7", 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/tx_scheduler.md
TX_SCHEDULER -- requirements
Module: tx_scheduler

Interface
REQ-001 Parameters: MAX_UART_DATA_W, default 8, max UART data width. TOTAL_CONF_WIDTH, default 5, Tx conf width {data[1:0], stop[1:0], parity_en}. GAP_W, default 8, inter-character gap counter width.
REQ-002 Ports, one per line (name  direction  width  meaning); single clock; synchronous active-high reset:
- clk_i  in  1  top clock
- rst_i  in  1  synchronous active-high reset
- baud_en_i  in  1  baud-rate sample enable
- enable_i  in  1  scheduler enable; also drives the Tx enable
- gap_i  in  GAP_W  idle baud_en ticks inserted after each character
- tx_conf_i  in  TOTAL_CONF_WIDTH  shared line configuration
- req0_valid_i  in  1  requester 0 (host) has data
- req0_data_i  in  MAX_UART_DATA_W  requester 0 data
- req0_ready_o  out  1  requester 0 accept pulse
- req1_valid_i  in  1  requester 1 (echo) has data
- req1_data_i  in  MAX_UART_DATA_W  requester 1 data
- req1_ready_o  out  1  requester 1 accept pulse
- tx_busy_i  in  1  busy status from Tx module
- tx_done_i  in  1  done pulse from Tx module
- tx_en_o  out  1  Tx module enable
- tx_start_o  out  1  Tx start request
- tx_data_o  out  MAX_UART_DATA_W  held character
- tx_conf_o  out  TOTAL_CONF_WIDTH  held configuration
- grant_o  out  1  index of the last accepted requester
- sched_busy_o  out  1  a character is in flight or a gap is running
- char_count_o  out  16  characters completed; wraps at 0xFFFF->0
- err_o  out  1  sticky start-timeout flag
- err_clr_i  in  1  clears err_o

Function
REQ-003 States: Disabled, Idle, Start, WaitDone, Gap. All transitions occur on clk_i edges. baud_en_i qualifies only the gap and timeout counters.
REQ-004 Disabled: enter Idle when enable_i=1.
REQ-005 Idle with enable_i=0: go to Disabled.
REQ-006 Idle with any valid: accept exactly one request. Pulse the matching reqN_ready_o for one cycle. Register data into tx_data_o and tx_conf_i into tx_conf_o. Update grant_o. Go to Start.
REQ-007 Arbitration is round-robin. With both valid, grant the requester not equal to grant_o. With one valid, grant that requester.
REQ-008 Start: hold tx_start_o=1. When tx_busy_i=1, drop tx_start_o next cycle and go to WaitDone.
REQ-009 Start timeout: 32 baud_en_i ticks without tx_busy_i sets err_o, drops tx_start_o, and returns to Idle; the character is discarded.
REQ-010 WaitDone: on tx_done_i, increment char_count_o. Go to Gap if gap_i!=0, otherwise Idle.
REQ-011 Gap: count baud_en_i ticks. Go to Idle once gap_i ticks have elapsed; gap_i is sampled at Gap entry.
REQ-012 tx_data_o and tx_conf_o stay stable from acceptance until the next acceptance.
REQ-013 Dropping enable_i mid-character does not abort. Completion follows REQ-010/011, then Idle -> Disabled.
REQ-014 tx_en_o=enable_i OR (state is not Disabled/Idle), so the Tx module is never disabled mid-frame.
REQ-015 sched_busy_o=1 in Start, WaitDone and Gap.
REQ-016 err_clr_i clears err_o. If clear and set coincide, set wins.
REQ-017 No ready pulse occurs outside Idle. Valid may drop without acceptance; there is no holding requirement.

Reset
REQ-018 On rst_i: state=Disabled; tx_start_o, reqN_ready_o, err_o, sched_busy_o=0; grant_o=1 (requester 0 wins the first tie); char_count_o, tx_data_o, tx_conf_o, counters=0. tx_en_o=enable_i.
REQ-019 Reset mid-character drops tx_start_o on the next cycle. The in-flight character is not counted.

Structure
REQ-020 Shared package holds: state encoding, start-timeout constant (32), conf field widths, and the reset value of grant_o.
REQ-021 One sub-module, rr_arbiter2: 2-input round-robin grant from the valids and the last grant. Everything else is flat.

Verification
REQ-022 Single request: req0 0xA5, conf 5'b11001, gap 0 -> req0_ready pulses once; tx_start_o high until tx_busy_i; after tx_done_i, char_count_o=1.
REQ-023 Contention: req0 and req1 continuously valid with 0x11/0x22 -> accepted order 0x11, 0x22, 0x11, 0x22; grant_o alternates 0,1,0,1.
REQ-024 Gap: gap_i=3 -> exactly 3 baud_en_i ticks between tx_done_i and the next ready pulse.
REQ-025 Timeout: tx_busy_i held 0 -> err_o=1 after 32 baud ticks, state Idle. err_clr_i -> err_o=0.
REQ-026 enable_i deasserted during WaitDone -> tx_en_o stays 1 until done, then Disabled; valid is ignored.
REQ-027 Wrap and reset: char_count_o=0xFFFF plus one character -> 0. rst_i during Start -> all outputs at reset values next cycle.
